// File: rtl/arrow_track.sv
// Scrolling arrow track for the rhythm game: an LFSR feeds the tail, the head is
// presented to the comparison stage, and un-hit arrows leaving the head count as misses.
module arrow_track #(
    parameter int          DEPTH    = 8,
    parameter logic [7:0]  SEED     = 8'hA5,
    parameter int          MAX_MISS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tick,
    input  logic                 hit,
    output logic [2:0]           first,
    output logic [3*DEPTH-1:0]   track,
    output logic                 miss,
    output logic [3:0]           miss_count,
    output logic                 game_over
);

    localparam logic [2:0]         BLANK      = 3'b100;
    localparam logic [7:0]         SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0]         MAX_MISS_L = 4'(MAX_MISS);
    localparam logic [3*DEPTH-1:0] ALL_BLANK  = {DEPTH{BLANK}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3*DEPTH-1:0]   track_q, track_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 miss_q, miss_d;
    logic [3:0]           miss_count_q, miss_count_d;
    logic [2:0]           new_arrow;
    logic [2:0]           head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            track_q      <= ALL_BLANK;
            lfsr_q       <= SEED_EFF;
            miss_q       <= 1'b0;
            miss_count_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            lfsr_q       <= lfsr_d;
            miss_q       <= miss_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        lfsr_d       = lfsr_q;
        miss_d       = 1'b0;
        miss_count_d = miss_count_q;
        head         = track_q[2:0];
        // The tail arrow comes from the LFSR value before this tick's advance.
        new_arrow    = lfsr_q[2] ? BLANK : {1'b0, lfsr_q[1:0]};

        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (tick) begin
                    track_d = {new_arrow, track_q[3*DEPTH-1:3]};
                    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    // A hit arriving with the tick belongs to the departing head.
                    if (head != BLANK && !hit) begin
                        miss_d = 1'b1;
                        if (miss_count_q != 4'd15) miss_count_d = miss_count_q + 4'd1;
                        if (miss_count_d >= MAX_MISS_L) state_d = OVER;
                    end
                end else if (hit && head != BLANK) begin
                    track_d[2:0] = BLANK;
                end
            end
            OVER: begin
                if (start) begin
                    track_d      = ALL_BLANK;
                    miss_count_d = 4'd0;
                    state_d      = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign first      = track_q[2:0];
    assign track      = track_q;
    assign miss       = miss_q;
    assign miss_count = miss_count_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_arrow_track.sv
// Directed bench for arrow_track: a queue-based game model checked every cycle,
// plus hand-computed literal expectations for the SEED=A5 scroll sequence.
module tb_arrow_track;

    localparam int DEPTH = 8;
    localparam int MAXM  = 2;
    localparam logic [3*DEPTH-1:0] ALL_BLANK = {DEPTH{3'b100}};

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 tick = 1'b0;
    logic                 hit = 1'b0;
    logic [2:0]           first;
    logic [3*DEPTH-1:0]   track;
    logic                 miss;
    logic [3:0]           miss_count;
    logic                 game_over;

    int total = 0;
    int bad   = 0;

    // Game model: queue index 0 is the head.
    int   m_track[$];
    int   m_lfsr;
    int   m_miss_count;
    bit   m_miss;
    int   m_mode;     // 0 idle, 1 playing, 2 game over
    bit   m_valid = 1'b0;

    arrow_track #(.DEPTH(DEPTH), .SEED(8'hA5), .MAX_MISS(MAXM)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .hit(hit),
        .first(first), .track(track), .miss(miss),
        .miss_count(miss_count), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int arrow_of(input int l);
        if ((l / 4) % 2 == 1) return 4;
        return l % 4;
    endfunction

    function automatic int lfsr_next(input int l);
        int taps;
        taps = ((l >> 7) + (l >> 5) + (l >> 4) + (l >> 3)) & 1;
        return ((l * 2) % 256) + taps;
    endfunction

    function automatic logic [3*DEPTH-1:0] pack_model();
        logic [3*DEPTH-1:0] p;
        int v;
        p = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = m_track[i];
            p[3*i +: 3] = v[2:0];
        end
        return p;
    endfunction

    task automatic clear_model_track();
        m_track.delete();
        for (int i = 0; i < DEPTH; i++) m_track.push_back(4);
    endtask

    task automatic model_apply(input bit r, input bit s, input bit t, input bit h);
        int gone;
        if (r) begin
            clear_model_track();
            m_lfsr = 8'hA5;
            m_mode = 0;
            m_miss_count = 0;
            m_miss = 0;
            m_valid = 1'b1;
            return;
        end
        m_miss = 0;
        if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (t) begin
                gone = m_track.pop_front();
                m_track.push_back(arrow_of(m_lfsr));
                m_lfsr = lfsr_next(m_lfsr);
                if (gone != 4 && !h) begin
                    m_miss = 1;
                    if (m_miss_count < 15) m_miss_count++;
                    if (m_miss_count >= MAXM) m_mode = 2;
                end
            end else if (h && m_track[0] != 4) begin
                m_track[0] = 4;
            end
        end else begin
            if (s) begin
                clear_model_track();
                m_miss_count = 0;
                m_mode = 1;
            end
        end
    endtask

    // One clock: drive inputs, model the edge, return #1 after the edge.
    task automatic step(input bit r, input bit s, input bit t, input bit h);
        rst = r; start = s; tick = t; hit = h;
        @(posedge clk);
        model_apply(r, s, t, h);
        #1;
        rst = 0; start = 0; tick = 0; hit = 0;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_first", 32'(first), 32'(m_track[0]));
            chk("cmp_track", 32'(track), 32'(pack_model()));
            chk("cmp_miss", 32'(miss), 32'(m_miss));
            chk("cmp_miss_count", 32'(miss_count), 32'(m_miss_count));
            chk("cmp_game_over", 32'(game_over), 32'(m_mode == 2));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_first", 32'(first), 32'h4);
        chk("rst_track", 32'(track), 32'(ALL_BLANK));
        chk("rst_game_over", 32'(game_over), 32'h0);
        chk("rst_miss_count", 32'(miss_count), 32'h0);

        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        chk("idle_ticks_track", 32'(track), 32'(ALL_BLANK));

        step(0, 1, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
            if (k == 1) chk("t1_slot7", 32'(track[23:21]), 32'h4);
            if (k == 2) begin
                chk("t2_slot7", 32'(track[23:21]), 32'h2);
                chk("t2_slot6", 32'(track[20:18]), 32'h4);
            end
            if (k == 4) begin
                chk("t4_slot7", 32'(track[23:21]), 32'h2);
                chk("t4_slot5", 32'(track[17:15]), 32'h2);
            end
            if (k == 9) chk("t9_first", 32'(first), 32'h2);
        end

        step(0, 0, 1, 0);
        chk("t10_miss", 32'(miss), 32'h1);
        chk("t10_miss_count", 32'(miss_count), 32'h1);
        step(0, 0, 0, 0);
        chk("t10_miss_one_cycle", 32'(miss), 32'h0);

        step(0, 0, 1, 0);
        chk("t11_first", 32'(first), 32'h2);
        step(0, 0, 0, 1);
        chk("hit_consumes_head", 32'(first), 32'h4);
        step(0, 0, 1, 0);
        chk("t12_no_miss", 32'(miss), 32'h0);
        chk("t12_miss_count", 32'(miss_count), 32'h1);
        step(0, 0, 1, 0);
        chk("t13_first", 32'(first), 32'h1);
        step(0, 0, 1, 1);
        chk("hit_with_tick_no_miss", 32'(miss), 32'h0);
        chk("hit_with_tick_count", 32'(miss_count), 32'h1);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("t15_game_over", 32'(game_over), 32'h1);
        chk("t15_miss_count", 32'(miss_count), 32'h2);

        for (int i = 0; i < 3; i++) step(0, 0, 1, i % 2);
        step(0, 1, 0, 0);
        chk("restart_track", 32'(track), 32'(ALL_BLANK));
        chk("restart_count", 32'(miss_count), 32'h0);
        chk("restart_game_over", 32'(game_over), 32'h0);

        n = 0;
        while (m_miss_count != 1 && n < 40) begin
            step(0, 0, 1, 0);
            n++;
        end
        chk("reach_one_miss", 32'(miss_count), 32'h1);
        step(1, 0, 1, 0);
        chk("midgame_rst_track", 32'(track), 32'(ALL_BLANK));
        chk("midgame_rst_count", 32'(miss_count), 32'h0);
        chk("midgame_rst_game_over", 32'(game_over), 32'h0);
        step(0, 0, 1, 0);
        chk("post_rst_idle_track", 32'(track), 32'(ALL_BLANK));
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("reseed_t1_slot7", 32'(track[23:21]), 32'h4);
        step(0, 0, 1, 0);
        chk("reseed_t2_slot7", 32'(track[23:21]), 32'h2);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arrow_track.md
Name: arrow_track

Overview:
Upstream arrow source for the rhythm-game comparison stage. It keeps a DEPTH-slot scrolling track of 3-bit arrow codes, filled from an 8-bit LFSR, and presents the head slot as `first` to the comparison block. It consumes the comparison block's `success` as `hit`, counts arrows that scroll off un-hit, and ends the game after MAX_MISS misses.

Parameters:
DEPTH, 8, number of track slots; slot 0 is the head; legal range 2–16.
SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.
MAX_MISS, 5, number of misses that ends the game; legal range 1–15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a game.
tick  input  1  one-cycle scroll strobe, from the game-rate divider.
hit  input  1  success from the comparison stage for the current head.
first  output  3  head arrow code: 000 up, 001 right, 010 down, 011 left, 100 blank.
track  output  3*DEPTH  all slots; slot i occupies bits [3i+2:3i]; for the display.
miss  output  1  one-cycle pulse when a non-blank arrow leaves un-hit.
miss_count  output  4  saturating miss counter.
game_over  output  1  high while in state OVER.

Behaviour:
- Encoding: 101–111 never produced.
- Reset (rst=1 at an edge):
  - all slots = 100, so first = 100 and track is all blank.
  - lfsr = SEED; state = IDLE.
  - miss = 0, miss_count = 0, game_over = 0.
  - rst has priority over every other input.
- Outputs:
  - first = slot[0] and track are driven directly from registers, with no combinational path from inputs.
  - miss is a registered pulse.
- LFSR:
  - 8-bit Fibonacci; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only on an accepted tick in RUN.
  - New arrow = lfsr[2] ? 100 : {0, lfsr[1:0]}, computed from the value before the advance.
- States:
  - IDLE: tick and hit ignored; start -> RUN at the next edge.
  - RUN, on an edge with tick=1:
    - slot[i] <= slot[i+1] for i < DEPTH-1.
    - slot[DEPTH-1] <= new arrow.
    - The LFSR advances.
    - If the departing slot[0] != 100 and it was not hit this cycle: miss=1 next cycle and miss_count += 1, saturating at 15.
  - RUN, hit=1 with slot[0] != 100 and tick=0: slot[0] <= 100. The head is consumed, and the comparison block sees blank on the following cycle.
  - RUN, hit with slot[0] == 100: ignored.
  - RUN, hit and tick in the same cycle: the hit applies to the departing head, so no miss; the shift proceeds normally.
  - RUN -> OVER on the edge where miss_count becomes >= MAX_MISS. The shift of that edge still completes.
  - RUN, start: ignored.
  - OVER: game_over=1; track, LFSR and miss_count frozen; tick and hit ignored. start clears all slots to 100, sets miss_count=0 and miss=0, and moves to RUN next edge. The LFSR is not reseeded, so the next game differs.
- Default pulses: miss=0 on every edge without a qualifying miss.

Test Plan:
1. Reset: rst=1 for 2 cycles -> first=100, track all 100, miss_count=0, game_over=0, state IDLE; 5 ticks in IDLE leave the track all 100.
2. Scroll sequence (SEED=A5, DEPTH=8), start then tick pulses:
   - after tick 1: slot7=100.
   - after tick 2: slot7=010, slot6=100.
   - after tick 4: slot7=010, slot5=010.
   - after tick 9: first=010.
3. Miss: continue from 2 with hit=0; tick 10 -> miss=1 for exactly one cycle, miss_count=1; tick 12 -> miss_count=2.
4. Hit: with first=010, pulse hit without tick -> first=100 next cycle, and the next tick gives no miss. Separately, hit and tick in the same cycle -> no miss, miss_count unchanged.
5. Game over (MAX_MISS=2): run from 2 with hit=0 until the second miss -> game_over=1 the same cycle miss_count=2. Further ticks leave track unchanged. start -> track all 100, miss_count=0, game_over=0, scrolling resumes with LFSR continuing from its frozen value.
6. Reset mid-game: assert rst in RUN with non-blank slots and miss_count=1 -> next edge all slots 100, miss_count=0, lfsr=A5, IDLE. A tick in the same cycle as rst has no effect.
